// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch sequencer: reads {mem[base+1], mem[base]} and strobes pc_inc per byte.
// Optional wait-state timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clock,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] addr_in,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [15:0] mem_addr,
  output logic        mem_re,
  output logic        pc_inc,
  output logic [15:0] ir_out,
  output logic        ir_valid,
  output logic        done,
  output logic        busy,
  output logic        fetch_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : gBadTimeout
    $error("TIMEOUT_CYCLES must be in 2..255");
  end

  typedef enum logic [2:0] {
    StIdle,
    StRdLo,
    StRdHi,
    StDone,
    StErr
  } fetchStateT;

  fetchStateT  stateQ, stateD;
  logic [15:0] baseQ, baseD;
  logic [15:0] irQ, irD;
  logic        irValidQ, irValidD;
  logic        timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [7:0] WaitLast = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] waitQ, waitD;

  // Any cycle that is not an un-aborted wait cycle clears the counter.
  always_comb begin
    waitD = 8'd0;
    if ((stateQ == StRdLo || stateQ == StRdHi) && !abort && !mem_ready) begin
      waitD = waitQ + 8'd1;
    end
  end

  assign timeout = (waitQ == WaitLast);

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      waitQ <= 8'd0;
    end else begin
      waitQ <= waitD;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    stateD    = stateQ;
    baseD     = baseQ;
    irD       = irQ;
    irValidD  = irValidQ;
    mem_addr  = 16'h0000;
    mem_re    = 1'b0;
    pc_inc    = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    fetch_err = 1'b0;
    case (stateQ)
      StIdle: begin
        if (abort) begin
          irValidD = 1'b0;
        end else if (start) begin
          baseD    = addr_in;
          irValidD = 1'b0;
          stateD   = StRdLo;
        end
      end
      StRdLo, StRdHi: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = (stateQ == StRdHi) ? baseQ + 16'd1 : baseQ;
        if (abort) begin
          irValidD = 1'b0;
          stateD   = StIdle;
        end else if (mem_ready) begin
          pc_inc = 1'b1;
          if (stateQ == StRdLo) begin
            irD[7:0] = mem_rdata;
            stateD   = StRdHi;
          end else begin
            irD[15:8] = mem_rdata;
            stateD    = StDone;
          end
        end else if (timeout) begin
          irValidD = 1'b0;
          stateD   = StErr;
        end
      end
      StDone: begin
        done     = 1'b1;
        irValidD = 1'b1;
        stateD   = StIdle;
      end
      StErr: begin
`ifdef FETCH_TIMEOUT_EN
        fetch_err = 1'b1;
`endif
        stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge rst) begin
    if (rst) begin
      stateQ   <= StIdle;
      baseQ    <= 16'h0000;
      irQ      <= 16'h0000;
      irValidQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      baseQ    <= baseD;
      irQ      <= irD;
      irValidQ <= irValidD;
    end
  end

  assign ir_out   = irQ;
  assign ir_valid = irValidQ;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch sequencer directly downstream of the PC/AR/SP address register file.
- Consumes the 16-bit address driven on the register file's OutD (OutDSel selecting PC) and reads two bytes from byte-wide memory.
- Assembles them into a 16-bit instruction register and emits one PC-increment strobe per byte consumed; the strobe drives the register file's enable/FunSel increment path.

Parameters:
- TIMEOUT_CYCLES, 16, max consecutive wait cycles per byte before abort (used only with FETCH_TIMEOUT_EN); legal range 2..255.

Ports:
- Clock  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a fetch; sampled only in IDLE
- abort  in  1  cancel an in-progress fetch
- addr_in  in  16  fetch base address (register file OutD)
- mem_rdata  in  8  memory read data
- mem_ready  in  1  mem_rdata valid for the current mem_addr this cycle
- mem_addr  out  16  memory byte address
- mem_re  out  1  memory read enable
- pc_inc  out  1  one-cycle strobe: increment PC at this edge
- ir_out  out  16  assembled instruction {high byte, low byte}
- ir_valid  out  1  ir_out holds a complete fetched instruction
- done  out  1  one-cycle pulse: fetch completed
- busy  out  1  fetch in progress
- fetch_err  out  1  one-cycle pulse: fetch timed out

Behaviour:
- Reset (async, immediate): state=IDLE; base=0; ir_out=16'h0000; ir_valid=0; wait counter=0. Combinational outputs follow from IDLE: mem_re=0, mem_addr=0, pc_inc=0, done=0, busy=0, fetch_err=0.
- States: IDLE, RD_LO, RD_HI, DONE, ERR. Encoding is free.
- IDLE:
  - busy=0.
  - start=1 and abort=0: latch base<=addr_in, clear ir_valid, go to RD_LO.
  - start=1 and abort=1 in the same cycle: abort wins; start is ignored.
- RD_LO:
  - busy=1, mem_re=1, mem_addr=base.
  - mem_ready=1: ir_out[7:0]<=mem_rdata, go to RD_HI.
  - mem_ready=0: stay.
- RD_HI:
  - busy=1, mem_re=1, mem_addr=base+1, computed mod 2^16 (16'hFFFF wraps to 16'h0000).
  - mem_ready=1: ir_out[15:8]<=mem_rdata, go to DONE.
  - mem_ready=0: stay.
- pc_inc is combinational: 1 exactly when state is RD_LO or RD_HI, mem_ready=1 and abort=0. It yields exactly 2 strobes per completed fetch.
- DONE:
  - done=1, busy=0, ir_valid<=1.
  - Next cycle go to IDLE unconditionally; start is ignored in DONE.
- ir_valid stays 1 until the next accepted start, an abort, or rst. ir_out holds its value while in IDLE.
- Byte order is little-endian: low byte at base, high byte at base+1.
- abort=1 in RD_LO or RD_HI:
  - Go to IDLE at the next edge; abort beats mem_ready.
  - No capture and no pc_inc in that cycle; ir_valid<=0.
  - A partially updated ir_out is permitted but must not be flagged valid.
- addr_in changes after start is accepted have no effect (base is latched).
- Minimum fetch latency with mem_ready held high: start accepted at edge 0, RD_LO capture at edge 1, RD_HI capture at edge 2, done high during the cycle after edge 2. Back-to-back fetches are therefore 4 cycles apart.
- mem_ready outside RD_LO/RD_HI is ignored.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - 8-bit wait counter increments each RD_LO/RD_HI cycle with mem_ready=0.
  - Counter clears on a byte capture, on entering RD_LO, on abort and on rst.
  - When the counter equals TIMEOUT_CYCLES-1 and mem_ready=0: go to ERR and clear ir_valid.
  - ERR: fetch_err=1, busy=0 for one cycle, then IDLE.
  - No pc_inc is issued for the timed-out byte.
- Not defined: no counter or ERR logic; fetch_err tied 0; waits indefinitely for mem_ready.

Test Plan:
- Reset mid-fetch (rst asserted in RD_HI): all outputs return to reset values immediately without a clock edge; ir_valid=0; no pc_inc.
- Basic fetch, addr_in=16'h0040, memory[0x40]=8'h34, memory[0x41]=8'h12, mem_ready always 1: mem_addr sequence 0040 then 0041; 2 pc_inc strobes; ir_out=16'h1234, ir_valid=1; done pulses once, 3 cycles after start.
- Wrap-around, addr_in=16'hFFFF, memory[FFFF]=8'hCD, memory[0000]=8'hAB: second mem_addr=16'h0000; ir_out=16'hABCD.
- Wait states, mem_ready low 3 cycles before each byte: mem_addr held stable while waiting; pc_inc only in the ready cycles; done 9 cycles after start.
- Abort in RD_HI in the same cycle as mem_ready=1: exactly 1 pc_inc total; ir_valid=0; busy=0 next cycle; a following start is accepted normally.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready stuck 0 in RD_LO: fetch_err pulses once after 4 wait cycles; zero pc_inc; ir_valid=0; returns to IDLE. Without the macro: busy stays 1 and fetch_err=0.
